mem_port_arb: RTL and testbench
===============================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter: ADDR_W, 16, width of the word address.
REQ-002 Parameter: DATA_W, 16, width of the data word.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Ports, per requester x in {a,b}: x_req  input  1  request valid.
REQ-006 Ports: x_we  input  1  1 = write, 0 = read.
REQ-007 Ports: x_addr  input  ADDR_W  word address.
REQ-008 Ports: x_wdata  input  DATA_W  write data.
REQ-009 Ports: x_gnt  output  1  request accepted this cycle.
REQ-010 Ports: x_rvalid  output  1  read data valid for x.
REQ-011 Ports: x_rdata  output  DATA_W  read data for x.
REQ-012 Port: mem_raddr  output  ADDR_W  to memory read port 1 address.
REQ-013 Port: mem_rdata  input  DATA_W  from memory read port 1 data.
REQ-014 Ports: mem_we  output  1, mem_waddr  output  ADDR_W, mem_wdata  output  DATA_W  memory write port.
REQ-015 Port: conflict_cnt  output  16  count of cycles where both requesters requested.

Function
REQ-016 The block SHALL accept at most one transaction per cycle; a transaction is accepted in the cycle x_req=1 and x_gnt=1.
REQ-017 x_gnt SHALL be combinational from x_req and arbitration state; a requester holds req, we, addr and wdata stable until granted.
REQ-018 Only one requester requesting: it SHALL be granted that cycle.
REQ-019 Both requesting: the requester not granted most recently SHALL win; the last-grant pointer (reset value a granted last, so b wins the first tie) SHALL update on every grant.
REQ-020 Accepted write: mem_we=1, mem_waddr=x_addr, mem_wdata=x_wdata in the same cycle; otherwise mem_we=0.
REQ-021 Accepted read: mem_raddr=x_addr in the same cycle; when no read is accepted, mem_raddr SHALL hold its previous value.
REQ-022 Memory read latency is two edges (address sampled at edge N, data valid after edge N+1); a 2-stage tag pipeline {valid, owner} SHALL track each accepted read.
REQ-023 Read accepted in cycle C: owner's x_rvalid=1 for exactly cycle C+2, x_rdata=mem_rdata combinationally; the other requester's rvalid=0.
REQ-024 x_rdata SHALL be 0 whenever x_rvalid=0.
REQ-025 Back-to-back reads (any mix of owners) SHALL each return in order, one per cycle, without stalls.
REQ-026 Write to address A accepted in cycle C followed by a read of A accepted in cycle C+1 or later SHALL return the new data.
REQ-027 conflict_cnt SHALL increment on every cycle with a_req=1 and b_req=1, saturating at 16'hFFFF.

Reset
REQ-028 While rst_n=0: x_gnt=0, mem_we=0, x_rvalid=0, x_rdata=0, mem_raddr=0, tag pipeline cleared, last-grant=a, conflict_cnt=0.
REQ-029 Reads in flight when rst_n asserts SHALL be dropped; no rvalid for them after deassertion.
REQ-030 First edge after rst_n deasserts SHALL behave as a normal cycle.

Verification
REQ-031 a read 0x0010 (mem[0x10]=0x1234), b idle -> a_gnt=1 cycle 0, a_rvalid=1 with a_rdata=0x1234 in cycle 2 only.
REQ-032 a and b both read every cycle for 4 cycles -> grants b,a,b,a; rvalids b,a,b,a in cycles 2-5; conflict_cnt=4.
REQ-033 a writes 0xBEEF to 0x0020 cycle 0, b reads 0x0020 cycle 1 -> b_rvalid cycle 3 with 0xBEEF; mem_we high only cycle 0.
REQ-034 a read accepted cycle 0, rst_n low in cycle 1, released cycle 3 -> no a_rvalid in cycles 1-5; all outputs 0 during reset.
REQ-035 Both requesting for 70000 cycles -> conflict_cnt stays 16'hFFFF, no wrap.

Source files
------------

// File: rtl/mem_port_arb.sv
// Two-requester arbiter in front of a single-write / single-read memory port.
// Grants are combinational; read data returns two cycles after acceptance and
// is steered back to its owner by a {valid, owner} tag pipeline.
module mem_port_arb #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester a
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  // requester b
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  // memory
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  // statistics
  output logic [15:0]       conflict_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_last_b;   // 1 = b was granted most recently
  logic [ADDR_W-1:0] r_raddr;    // last accepted read address
  logic              r_s1_vld;
  logic              r_s1_own;   // 1 = owner is b
  logic              r_s2_vld;
  logic              r_s2_own;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_acc;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_wr;
  logic              w_rd;
  logic              w_both;

  // Arbitration: lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && b_req) begin
        w_a_gnt = r_last_b;
        w_b_gnt = !r_last_b;
      end else begin
        w_a_gnt = a_req;
        w_b_gnt = b_req;
      end
    end
  end

  // Select the winning requester's transaction.
  always_comb begin
    w_acc       = w_a_gnt | w_b_gnt;
    w_sel_we    = w_b_gnt ? b_we    : a_we;
    w_sel_addr  = w_b_gnt ? b_addr  : a_addr;
    w_sel_wdata = w_b_gnt ? b_wdata : a_wdata;
    w_wr        = w_acc & w_sel_we;
    w_rd        = w_acc & ~w_sel_we;
    w_both      = a_req & b_req;
  end

  // Last-grant pointer; reset makes b the winner of the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b0;
    end else if (w_acc) begin
      r_last_b <= w_b_gnt;
    end
  end

  // Read address hold register so mem_raddr is stable between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr <= '0;
    end else if (w_rd) begin
      r_raddr <= w_sel_addr;
    end
  end

  // Two-stage tag pipeline matching the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_own <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s2_own <= 1'b0;
    end else begin
      r_s1_vld <= w_rd;
      r_s1_own <= w_b_gnt;
      r_s2_vld <= r_s1_vld;
      r_s2_own <= r_s1_own;
    end
  end

  // Saturating count of cycles where both requesters asked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_both && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign a_gnt        = w_a_gnt;
  assign b_gnt        = w_b_gnt;
  assign mem_we       = w_wr;
  assign mem_waddr    = w_wr ? w_sel_addr  : '0;
  assign mem_wdata    = w_wr ? w_sel_wdata : '0;
  assign mem_raddr    = w_rd ? w_sel_addr  : r_raddr;
  assign a_rvalid     = r_s2_vld & ~r_s2_own;
  assign b_rvalid     = r_s2_vld &  r_s2_own;
  assign a_rdata      = a_rvalid ? mem_rdata : '0;
  assign b_rdata      = b_rvalid ? mem_rdata : '0;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: vector table for grants/write port, scoreboard queue
// for returned read data, hand sequences for reset-in-flight and saturation.
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_we;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_port_arb #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .conflict_cnt(conflict_cnt)
  );

  function automatic logic [15:0] init_val(input int i);
    if (i == 16'h0010) return 16'h1234;
    return (16'(i) * 16'h0101) ^ 16'h3C5A;
  endfunction

  // Memory model: address sampled at one edge, data presented after the next.
  logic [15:0] env_mem [0:65535];
  logic [15:0] env_addr_q, env_rdata_q;
  initial begin
    for (int i = 0; i < 65536; i++) env_mem[i] = init_val(i);
    env_addr_q  = '0;
    env_rdata_q = '0;
    forever begin
      @(posedge clk);
      env_rdata_q = env_mem[env_addr_q];
      env_addr_q  = mem_raddr;
      if (mem_we) env_mem[mem_waddr] = mem_wdata;
    end
  end
  assign mem_rdata = env_rdata_q;

  typedef struct {
    logic        a_req, a_we;
    logic [15:0] a_addr, a_wdata;
    logic        b_req, b_we;
    logic [15:0] b_addr, b_wdata;
    logic        exp_a_gnt, exp_b_gnt;
  } vec_t;

  typedef struct packed {
    logic        own_b;
    logic [15:0] data;
    logic [31:0] due;
  } rd_t;

  logic [15:0] ref_mem [0:65535];
  rd_t         sb_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [15:0] exp_raddr = '0;
  logic [15:0] exp_cnt   = '0;
  vec_t        seg1 [0:19];
  vec_t        seg2 [0:3];

  function automatic vec_t mk(input logic ar, input logic aw, input logic [15:0] aa,
                              input logic [15:0] ad, input logic br, input logic bw,
                              input logic [15:0] ba, input logic [15:0] bd,
                              input logic ega, input logic egb);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.exp_a_gnt = ega; v.exp_b_gnt = egb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    chk("rst_b_gnt", 32'(b_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_a_rd", 32'({a_rvalid, a_rdata}), 32'd0);
    chk("rst_b_rd", 32'({b_rvalid, b_rdata}), 32'd0);
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
  endtask

  // Compare both read-return ports against the scoreboard head.
  task automatic chk_read_return();
    logic        ea, eb;
    logic [15:0] ed;
    rd_t         e;
    ea = 1'b0; eb = 1'b0; ed = '0;
    if (sb_q.size() != 0 && sb_q[0].due == 32'(cyc)) begin
      e  = sb_q.pop_front();
      ea = !e.own_b;
      eb = e.own_b;
      ed = e.data;
    end
    chk("a_rvalid_rdata", 32'({a_rvalid, a_rdata}), 32'({ea, ea ? ed : 16'h0000}));
    chk("b_rvalid_rdata", 32'({b_rvalid, b_rdata}), 32'({eb, eb ? ed : 16'h0000}));
  endtask

  // One clock cycle: drive at negedge, check combinational results, update model.
  task automatic do_cycle(input vec_t v, input logic rel);
    logic        acc, we;
    logic [15:0] addr, wd;
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
    #1;
    cyc++;
    chk("a_gnt", 32'(a_gnt), 32'(v.exp_a_gnt));
    chk("b_gnt", 32'(b_gnt), 32'(v.exp_b_gnt));
    acc  = v.exp_a_gnt | v.exp_b_gnt;
    we   = v.exp_b_gnt ? v.b_we    : v.a_we;
    addr = v.exp_b_gnt ? v.b_addr  : v.a_addr;
    wd   = v.exp_b_gnt ? v.b_wdata : v.a_wdata;
    chk("mem_we", 32'(mem_we), 32'(acc & we));
    if (acc && we) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(wd));
    end
    if (acc && !we) exp_raddr = addr;
    chk("mem_raddr", 32'(mem_raddr), 32'(exp_raddr));
    chk_read_return();
    chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
    if (v.a_req && v.b_req && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    if (acc && !we) sb_q.push_back('{own_b: v.exp_b_gnt, data: ref_mem[addr], due: 32'(cyc + 2)});
    if (acc && we) ref_mem[addr] = wd;
  endtask

  task automatic drain();
    int   g;
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    g = 0;
    while (sb_q.size() != 0 && g < 8) begin
      do_cycle(idle, 1'b0);
      g++;
    end
    chk("sb_drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);

    // single read, tie rotation, write-then-read, mixed read/write ties
    seg1[0]  = mk(1, 0, 16'h0010, 0, 0, 0, 0, 0, 1, 0);
    seg1[1]  = idle;
    seg1[2]  = idle;
    seg1[3]  = mk(1, 0, 16'h0030, 0, 1, 0, 16'h0031, 0, 0, 1);
    seg1[4]  = mk(1, 0, 16'h0030, 0, 1, 0, 16'h0032, 0, 1, 0);
    seg1[5]  = mk(1, 0, 16'h0033, 0, 1, 0, 16'h0032, 0, 0, 1);
    seg1[6]  = mk(1, 0, 16'h0033, 0, 1, 0, 16'h0034, 0, 1, 0);
    seg1[7]  = idle;
    seg1[8]  = idle;
    seg1[9]  = mk(1, 1, 16'h0020, 16'hBEEF, 0, 0, 0, 0, 1, 0);
    seg1[10] = mk(0, 0, 0, 0, 1, 0, 16'h0020, 0, 0, 1);
    seg1[11] = idle;
    seg1[12] = idle;
    seg1[13] = mk(0, 0, 0, 0, 1, 1, 16'h0050, 16'h7777, 0, 1);
    seg1[14] = mk(1, 0, 16'h0050, 0, 1, 1, 16'h0051, 16'h1111, 1, 0);
    seg1[15] = mk(0, 0, 0, 0, 1, 1, 16'h0051, 16'h1111, 0, 1);
    seg1[16] = mk(1, 0, 16'h0051, 0, 1, 0, 16'h0010, 0, 1, 0);
    seg1[17] = mk(0, 0, 0, 0, 1, 0, 16'h0010, 0, 0, 1);
    seg1[18] = idle;
    seg1[19] = idle;

    // after reset: first tie goes to b, then a alone
    seg2[0]  = mk(1, 0, 16'h0010, 0, 1, 0, 16'h0020, 0, 0, 1);
    seg2[1]  = mk(1, 0, 16'h0010, 0, 0, 0, 0, 0, 1, 0);
    seg2[2]  = idle;
    seg2[3]  = idle;

    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 1; b_we = 0; b_addr = 16'h0077; b_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs();

    for (int i = 0; i < 20; i++) do_cycle(seg1[i], i == 0);
    drain();

    // read accepted, then reset while it is in flight
    do_cycle(mk(1, 0, 16'h0060, 0, 0, 0, 0, 0, 1, 0), 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
    end
    sb_q.delete();
    exp_raddr = '0;
    exp_cnt   = '0;
    do_cycle(idle, 1'b1);
    do_cycle(idle, 1'b0);
    do_cycle(idle, 1'b0);

    for (int i = 0; i < 4; i++) do_cycle(seg2[i], 1'b0);
    drain();

    // both requesters held for 70000 cycles: counter must saturate
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      a_req = 1; a_we = 1; a_addr = 16'h0040; a_wdata = 16'hCAFE;
      b_req = 1; b_we = 1; b_addr = 16'h0040; b_wdata = 16'hCAFE;
      #1;
      if (i == 0) chk("sat_mem_we", 32'(mem_we), 32'd1);
      if (i == 0 || i == 65533 || i == 65534 || i == 69999)
        chk("sat_conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    ref_mem[16'h0040] = 16'hCAFE;
    do_cycle(idle, 1'b0);
    chk("sat_final", 32'(conflict_cnt), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
